teclado_deco: RTL and testbench

- Consumes the one-hot row scan `fila` from the ring counter and the raw column lines of a 4x4 matrix keypad.
- Synchronises the columns and aligns them with the delayed row.
- Debounces per scan slot and emits one registered key code plus a single-cycle valid pulse per press.
- Sits directly downstream of the row-scan ring counter and feeds the display/accumulator logic.

---
 rtl/teclado_deco.sv | 139 +++++++++++++
 tb/tb_teclado_deco.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/teclado_deco.sv
// 4x4 keypad decoder: synchronises columns against the delayed row scan, debounces each
// press/release per scan slot and emits one key code with a one-cycle valid pulse.
// Optional MULTIKEY_REJECT_EN: a slot with several active columns counts as "no key".
module teclado_deco #(
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int CNT_W            = $clog2(DEBOUNCE_SAMPLES+1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fila,
   input  logic [3:0] columna,
   output logic [3:0] tecla,
   output logic       tecla_valida,
   output logic       tecla_presionada
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, HELD} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES);

   state_t           state_q, state_d;
   logic [3:0]       col_m_q, col_s_q, fila_m_q, fila_d_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       cap_row_q, cap_row_d;
   logic [1:0]       cap_col_q, cap_col_d;
   logic [3:0]       tecla_q, tecla_d;
   logic             slot, eval, multi, key_hit, held_hit;
   logic [1:0]       sel_col;

   function automatic logic [3:0] key_code(input logic [3:0] row, input logic [1:0] col);
      logic [1:0] r;
      logic [3:0] code;
      r = row[3] ? 2'd3 : row[2] ? 2'd2 : row[1] ? 2'd1 : 2'd0;
      case ({r, col})
         4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
         4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
         4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
         4'd12: code = 4'hE;  4'd13: code = 4'h0;  4'd14: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         col_m_q   <= '0;
         col_s_q   <= '0;
         fila_m_q  <= '0;
         fila_d_q  <= '0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         cap_row_q <= '0;
         cap_col_q <= '0;
         tecla_q   <= '0;
      end else begin
         col_m_q   <= columna;
         col_s_q   <= col_m_q;
         fila_m_q  <= fila;
         fila_d_q  <= fila_m_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_row_q <= cap_row_d;
         cap_col_q <= cap_col_d;
         tecla_q   <= tecla_d;
      end
   end

   // Slot qualification, column priority encoder and the saturating counter increment.
   always_comb begin
      slot    = (fila_d_q != 4'd0) && ((fila_d_q & (fila_d_q - 4'd1)) == 4'd0);
      eval    = slot && (fila_d_q == cap_row_q);
      multi   = (col_s_q & (col_s_q - 4'd1)) != 4'd0;
      sel_col = col_s_q[0] ? 2'd0 : col_s_q[1] ? 2'd1 : col_s_q[2] ? 2'd2 : 2'd3;
`ifdef MULTIKEY_REJECT_EN
      key_hit  = (col_s_q != 4'd0) && !multi;
      held_hit = col_s_q[cap_col_q] || multi;
`else
      key_hit  = col_s_q != 4'd0;
      held_hit = col_s_q[cap_col_q];
`endif
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_row_d = cap_row_q;
      cap_col_d = cap_col_q;
      tecla_d   = tecla_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (slot && key_hit) begin
               cap_row_d = fila_d_q;
               cap_col_d = sel_col;
               cnt_d     = CNT_W'(1);
               state_d   = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (eval) begin
               if (key_hit && sel_col == cap_col_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_d = EMIT;
                     // Load the code now so it is visible together with the valid pulse.
                     tecla_d = key_code(cap_row_q, cap_col_q);
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         EMIT: begin
            cnt_d   = '0;
            state_d = HELD;
         end
         default: begin
            if (eval) begin
               if (held_hit) begin
                  cnt_d = '0;
               end else if (cnt_inc == CNT_MAX) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
      endcase
   end

   always_comb begin
      tecla            = tecla_q;
      tecla_valida     = (state_q == EMIT);
      tecla_presionada = (state_q == EMIT) || (state_q == HELD);
   end

endmodule

// File: tb/tb_teclado_deco.sv
// Directed bench for teclado_deco: ring-counter row scan plus keypad matrix model,
// expected key codes queued by the stimulus and consumed by a pulse monitor.
module tb_teclado_deco;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] fila = 4'b0001;
   logic [3:0] columna;
   logic [3:0] tecla;
   logic       tecla_valida, tecla_presionada;

   logic [3:0] keys [4];
   logic [3:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;

   teclado_deco #(.DEBOUNCE_SAMPLES(4)) dut (
      .clk(clk), .rst(rst), .fila(fila), .columna(columna),
      .tecla(tecla), .tecla_valida(tecla_valida), .tecla_presionada(tecla_presionada)
   );

   always #5 clk = ~clk;

   // Upstream ring counter
   initial forever begin
      @(posedge clk);
      #1 fila = {fila[2:0], fila[3]};
   end

   // Keypad matrix: a pressed key ties its row drive onto its column
   always_comb begin
      columna = 4'd0;
      for (int r = 0; r < 4; r++)
         if (fila[r]) columna = columna | keys[r];
   end

   always @(negedge clk) begin
      if (tecla_valida) begin
         logic [3:0] e;
         pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse tecla=%h expected no pulse", tecla);
         end else begin
            e = exp_q.pop_front();
            if (tecla !== e) begin
               errors++;
               $display("FAIL pulse_code tecla=%h expected=%h", tecla, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic press(input int r, input int c);
      for (int i = 0; i < 4; i++) keys[i] = 4'd0;
      keys[r][c] = 1'b1;
   endtask

   task automatic release_all();
      for (int i = 0; i < 4; i++) keys[i] = 4'd0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input string name, input int budget);
      int s, n;
      s = pulses;
      n = 0;
      while (pulses == s && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (pulses == s) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout got=no pulse expected=pulse within %0d cycles", name, budget);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) keys[i] = 4'hF;
      // Reset with every column active
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tecla", tecla, 4'h0);
      chk("rst_valida", {3'b0, tecla_valida}, 4'h0);
      chk("rst_presionada", {3'b0, tecla_presionada}, 4'h0);
      release_all();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_rst_valida", {3'b0, tecla_valida}, 4'h0);
      end
      cycles(2);

      // Stable '5'
      press(1, 1);
      exp_q.push_back(4'h5);
      wait_pulse("key5", 20);
      chk("key5_presionada", {3'b0, tecla_presionada}, 4'h1);
      cycles(10);
      release_all();
      cycles(8);
      chk("key5_still_held", {3'b0, tecla_presionada}, 4'h1);
      cycles(16);
      chk("key5_released", {3'b0, tecla_presionada}, 4'h0);
      chk("key5_tecla_hold", tecla, 4'h5);

      // Bounce on '#': 2 slots down, 1 slot up, then stable
      press(3, 2);
      cycles(8);
      release_all();
      cycles(4);
      press(3, 2);
      exp_q.push_back(4'hF);
      wait_pulse("keyF", 40);
      cycles(10);
      release_all();
      cycles(30);

      // '2' and 'A' together on row0
      keys[0] = 4'b1010;
`ifdef MULTIKEY_REJECT_EN
      cycles(40);
      chk("multi_tecla_unchanged", tecla, 4'hF);
`else
      exp_q.push_back(4'h2);
      wait_pulse("multi", 40);
`endif
      release_all();
      cycles(30);

      // '0' held long, then '9'
      press(3, 1);
      exp_q.push_back(4'h0);
      wait_pulse("key0", 40);
      cycles(100);
      chk("key0_tecla", tecla, 4'h0);
      chk("key0_presionada", {3'b0, tecla_presionada}, 4'h1);
      release_all();
      cycles(20);
      press(2, 2);
      exp_q.push_back(4'h9);
      wait_pulse("key9", 40);
      release_all();
      cycles(30);

      // Reset while '7' is held
      press(2, 0);
      exp_q.push_back(4'h7);
      wait_pulse("key7", 40);
      cycles(8);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_tecla", tecla, 4'h0);
      chk("midrst_presionada", {3'b0, tecla_presionada}, 4'h0);
      chk("midrst_valida", {3'b0, tecla_valida}, 4'h0);
      exp_q.push_back(4'h7);
      wait_pulse("key7_again", 40);
      release_all();
      cycles(30);

      chk("pending_expected", 4'(exp_q.size()), 4'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
